// File: rtl/count_seq_pkg.sv
// Shared definitions for the 24-state sequence decoder: code tables and FSM encoding.
package count_seq_pkg;

   localparam int unsigned CODE_W  = 5;
   localparam int unsigned SEQ_LEN = 24;

   typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_t;

   // Bit c set when code c belongs to the sequence; illegal: 18,20,21,22,25,26,27,29.
   localparam logic [31:0] LEGAL_MASK = 32'hD18B_FFFF;

   localparam logic [CODE_W-1:0] IDX_TAB [32] = '{
      5'd0,  5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,
      5'd8,  5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15,
      5'd23, 5'd22, 5'd0,  5'd21, 5'd0,  5'd0,  5'd0,  5'd20,
      5'd16, 5'd0,  5'd0,  5'd0,  5'd17, 5'd0,  5'd18, 5'd19
   };

   localparam logic [CODE_W-1:0] NXT_TAB [32] = '{
      5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,  5'd8,
      5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd24,
      5'd0,  5'd16, 5'd0,  5'd17, 5'd0,  5'd0,  5'd0,  5'd19,
      5'd28, 5'd0,  5'd0,  5'd0,  5'd30, 5'd0,  5'd31, 5'd23
   };

   function automatic logic code_legal(input logic [CODE_W-1:0] code);
      return LEGAL_MASK[code];
   endfunction

   function automatic logic [CODE_W-1:0] code_idx(input logic [CODE_W-1:0] code);
      return IDX_TAB[code];
   endfunction

   function automatic logic [CODE_W-1:0] code_nxt(input logic [CODE_W-1:0] code);
      return NXT_TAB[code];
   endfunction

endpackage

// File: rtl/count_seq_rom.sv
// Combinational lookup: code -> legality, sequence index and successor code.
module count_seq_rom
   import count_seq_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic              legal,
   output logic [CODE_W-1:0] idx,
   output logic [CODE_W-1:0] nxt
);

   assign legal = code_legal(code);
   assign idx   = code_idx(code);
   assign nxt   = code_nxt(code);

endmodule

// File: rtl/count_seq_decoder.sv
// Lock-on decoder / checker for the 24-state count code with flywheel error tolerance.
// Define SEQ_ERR_COUNT_EN to build the saturating err_count register; otherwise it reads 0.
module count_seq_decoder
   import count_seq_pkg::*;
#(
   parameter int unsigned LOCK_COUNT  = 3,
   parameter int unsigned UNLOCK_ERRS = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [CODE_W-1:0] code,
   input  logic              code_valid,
   output logic              locked,
   output logic [CODE_W-1:0] index,
   output logic              wrap,
   output logic              err,
   output logic [7:0]        err_count
);

   localparam logic [2:0] LockCnt   = 3'(LOCK_COUNT);
   localparam logic [2:0] UnlockCnt = 3'(UNLOCK_ERRS);

   state_t            state_q, state_d;
   logic [CODE_W-1:0] prev_q, prev_d;
   logic [2:0]        run_q, run_d, miss_q, miss_d;
   logic [CODE_W-1:0] index_q, index_d;
   logic              locked_q, locked_d, wrap_q, wrap_d, err_q, err_d;

   logic              in_legal, prev_legal;
   logic [CODE_W-1:0] in_idx, in_nxt, prev_idx, prev_nxt;

   count_seq_rom u_rom_code (
      .code  (code),
      .legal (in_legal),
      .idx   (in_idx),
      .nxt   (in_nxt)
   );

   count_seq_rom u_rom_prev (
      .code  (prev_q),
      .legal (prev_legal),
      .idx   (prev_idx),
      .nxt   (prev_nxt)
   );

   logic unused_rom;
   assign unused_rom = ^{in_nxt, prev_legal};

   logic       good;
   logic [2:0] run_inc, miss_inc;
   assign good     = in_legal && (code == prev_nxt);
   assign run_inc  = run_q + 3'd1;
   assign miss_inc = miss_q + 3'd1;

   always_comb begin
      state_d  = state_q;
      prev_d   = prev_q;
      run_d    = run_q;
      miss_d   = miss_q;
      index_d  = index_q;
      locked_d = locked_q;
      wrap_d   = 1'b0;
      err_d    = 1'b0;
      if (code_valid) begin
         unique case (state_q)
            StHunt: begin
               if (in_legal) begin
                  prev_d  = code;
                  run_d   = 3'd0;
                  state_d = StVerify;
               end
            end
            StVerify: begin
               if (good) begin
                  prev_d = code;
                  run_d  = run_inc;
                  if (run_inc == LockCnt) begin
                     state_d  = StLocked;
                     locked_d = 1'b1;
                     index_d  = in_idx;
                     miss_d   = 3'd0;
                  end
               end else if (in_legal) begin
                  prev_d = code;
                  run_d  = 3'd0;
               end else begin
                  state_d = StHunt;
               end
            end
            StLocked: begin
               if (good) begin
                  prev_d  = code;
                  index_d = in_idx;
                  miss_d  = 3'd0;
                  wrap_d  = (in_idx == '0);
               end else begin
                  // Flywheel: step past the bad sample as if the expected code arrived.
                  err_d   = 1'b1;
                  prev_d  = prev_nxt;
                  index_d = code_idx(prev_nxt);
                  miss_d  = miss_inc;
                  wrap_d  = (prev_idx == 5'(SEQ_LEN - 1));
                  if (miss_inc == UnlockCnt) begin
                     state_d  = StHunt;
                     locked_d = 1'b0;
                     index_d  = '0;
                  end
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= StHunt;
         prev_q   <= '0;
         run_q    <= '0;
         miss_q   <= '0;
         index_q  <= '0;
         locked_q <= 1'b0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         run_q    <= run_d;
         miss_q   <= miss_d;
         index_q  <= index_d;
         locked_q <= locked_d;
         wrap_q   <= wrap_d;
         err_q    <= err_d;
      end
   end

`ifdef SEQ_ERR_COUNT_EN
   logic [7:0] err_count_q;
   always_ff @(posedge clock) begin
      if (reset) begin
         err_count_q <= '0;
      end else if (err_d && (err_count_q != 8'hFF)) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end
   assign err_count = err_count_q;
`else
   assign err_count = 8'd0;
`endif

   assign locked = locked_q;
   assign index  = index_q;
   assign wrap   = wrap_q;
   assign err    = err_q;

endmodule

// File: tb/tb_count_seq_decoder.sv
// Scoreboard bench for count_seq_decoder: sequence-position reference model, directed + random.
module tb_count_seq_decoder;

   localparam int LOCK = 3;
   localparam int UNLK = 2;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] code = '0;
   logic       code_valid = 1'b0;
   logic       locked, wrap, err;
   logic [4:0] index;
   logic [7:0] err_count;

   count_seq_decoder #(
      .LOCK_COUNT  (LOCK),
      .UNLOCK_ERRS (UNLK)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .code       (code),
      .code_valid (code_valid),
      .locked     (locked),
      .index      (index),
      .wrap       (wrap),
      .err        (err),
      .err_count  (err_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic       locked;
      logic [4:0] index;
      logic       wrap;
      logic       err;
      logic [7:0] err_count;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   int seq [24] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15,
                    24, 28, 30, 31, 23, 19, 17, 16};

   // Reference model state: mode 0=hunt, 1=verify, 2=locked; prev is a sequence position.
   int m_mode, m_prev, m_run, m_miss, m_index, m_errcnt;
   bit m_locked;

   function automatic int pos_of(input int c);
      for (int i = 0; i < 24; i++) if (seq[i] == c) return i;
      return -1;
   endfunction

   task automatic chk(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   function automatic exp_t model(input bit rst, input bit valid, input int c);
      exp_t e;
      int   p;
      bit   good, wr, er;
      wr = 0;
      er = 0;
      if (rst) begin
         m_mode = 0; m_prev = 0; m_run = 0; m_miss = 0; m_index = 0; m_locked = 0;
         m_errcnt = 0;
      end else if (valid) begin
         p    = pos_of(c);
         good = (p >= 0) && (p == (m_prev + 1) % 24);
         case (m_mode)
            0: if (p >= 0) begin m_prev = p; m_run = 0; m_mode = 1; end
            1: begin
               if (good) begin
                  m_prev = p;
                  m_run++;
                  if (m_run == LOCK) begin
                     m_mode = 2; m_locked = 1; m_index = p; m_miss = 0;
                  end
               end else if (p >= 0) begin
                  m_prev = p; m_run = 0;
               end else begin
                  m_mode = 0;
               end
            end
            default: begin
               if (good) begin
                  m_prev = p; m_index = p; m_miss = 0; wr = (p == 0);
               end else begin
                  er = 1;
                  m_prev = (m_prev + 1) % 24;
                  m_index = m_prev;
                  wr = (m_prev == 0);
                  m_miss++;
                  if (m_miss == UNLK) begin
                     m_mode = 0; m_locked = 0; m_index = 0;
                  end
               end
            end
         endcase
`ifdef SEQ_ERR_COUNT_EN
         if (er && m_errcnt < 255) m_errcnt++;
`endif
      end
      e.locked    = m_locked;
      e.index     = 5'(m_index);
      e.wrap      = wr;
      e.err       = er;
      e.err_count = 8'(m_errcnt);
      return e;
   endfunction

   // One clock per call: drive at negedge, queue expectation, return just after the edge.
   task automatic step(input bit rst, input bit valid, input int c);
      @(negedge clock);
      reset      = rst;
      code_valid = valid;
      code       = 5'(c);
      exp_q.push_back(model(rst, valid, c));
      @(posedge clock);
      #2;
   endtask

   task automatic feed(input int c);
      step(0, 1, c);
   endtask

   // Monitor: outputs are presented every cycle, so compare one expectation per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_locked", locked, e.locked);
            chk("sb_index", index, e.index);
            chk("sb_wrap", wrap, e.wrap);
            chk("sb_err", err, e.err);
            chk("sb_err_count", err_count, e.err_count);
         end
      end
   end

   initial begin
      int feed_pos, prev_code, c, r;
      bit v;
      step(1, 1, 5);
      step(1, 0, 0);
      chk("reset_locked", locked, 0);
      chk("reset_index", index, 0);

      // Lock on 0..3
      for (int i = 0; i <= 3; i++) feed(i);
      chk("t1_locked", locked, 1);
      chk("t1_index", index, 3);

      // Run through to the wrap
      for (int i = 4; i <= 18; i++) feed(seq[i]);
      for (int i = 19; i <= 23; i++) begin
         feed(seq[i]);
         chk("t2_index", index, i);
         chk("t2_nowrap", wrap, 0);
      end
      feed(0);
      chk("t2_wrap_index", index, 0);
      chk("t2_wrap", wrap, 1);

      // Illegal code while locked at 5, then recovery
      for (int i = 1; i <= 5; i++) feed(i);
      feed(18);
      chk("t3_err", err, 1);
      chk("t3_fly_index", index, 6);
      feed(7);
      chk("t3_index", index, 7);
      chk("t3_err_clear", err, 0);
      chk("t3_locked", locked, 1);

      // Repeated code drops lock after two misses, then relock
      feed(8);
      feed(9);
      feed(9);
      chk("t4_err1", err, 1);
      feed(9);
      chk("t4_err2", err, 1);
      chk("t4_unlocked", locked, 0);
      for (int i = 0; i <= 3; i++) feed(i);
      chk("t4_relocked", locked, 1);

      // Hold with code_valid low
      for (int i = 4; i <= 12; i++) feed(i);
      for (int i = 0; i < 10; i++) step(0, 0, int'($urandom_range(0, 31)));
      chk("t5_index", index, 12);
      chk("t5_locked", locked, 1);

      // Reset wins over a valid sample
      step(1, 1, 13);
      chk("rst_win_locked", locked, 0);

`ifdef SEQ_ERR_COUNT_EN
      for (int n = 0; n < 150; n++) begin
         for (int i = 0; i <= 3; i++) feed(i);
         feed(3);
         feed(3);
      end
      chk("t6_sat", err_count, 255);
      step(1, 0, 0);
      chk("t6_clear", err_count, 0);
`endif

      // Random: mostly in-order codes with repeats, junk, gaps and rare resets
      feed_pos  = 0;
      prev_code = 0;
      for (int n = 0; n < 3000; n++) begin
         v = ($urandom_range(0, 9) != 0);
         r = int'($urandom_range(0, 99));
         if (r < 80) begin
            c = seq[feed_pos];
            if (v) feed_pos = (feed_pos + 1) % 24;
         end else if (r < 88) begin
            c = prev_code;
         end else begin
            c = int'($urandom_range(0, 31));
         end
         if (v) prev_code = c;
         step(r == 99 && $urandom_range(0, 3) == 0, v, c);
      end

      step(0, 0, 0);
      @(posedge clock);
      #3;
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
